// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, writeback port, issue port and status outputs.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] rd_din;
    logic              write_enable;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic [DATA_W-1:0] rs1_dout;
    logic [DATA_W-1:0] rs2_dout;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [DATA_W-1:0] ecall;

    modport master (
        output rs1, rs2, rd, rd_din, write_enable, iss_valid, iss_rd,
        input  rs1_dout, rs2_dout, rs1_busy, rs2_busy, ecall
    );

    modport slave (
        input  rs1, rs2, rd, rd_din, write_enable, iss_valid, iss_rd,
        output rs1_dout, rs2_dout, rs1_busy, rs2_busy, ecall
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two async read ports, one sync write port and a per-register pending scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_sb #(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 5,
    parameter int              SP_IDX    = 2,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h2ffc,
    parameter int              ECALL_IDX = 17
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic              wb_valid;
    logic              wb_hit1;
    logic              wb_hit2;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;

    assign wb_valid = bus.write_enable && (bus.rd != '0);
    assign wb_hit1  = wb_valid && (bus.rd == bus.rs1);
    assign wb_hit2  = wb_valid && (bus.rd == bus.rs2);

    // Issue beats writeback: a new producer to the same register is still outstanding.
    always_comb begin
        pending_nxt = pending;
        for (int r = 1; r < DEPTH; r++) begin
            if (bus.iss_valid && (bus.iss_rd == ADDR_W'(r))) begin
                pending_nxt[r] = 1'b1;
            end else if (bus.write_enable && (bus.rd == ADDR_W'(r))) begin
                pending_nxt[r] = 1'b0;
            end
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
            pending <= '0;
        end else begin
            if (wb_valid) begin
                rf[bus.rd] <= bus.rd_din;
            end
            pending <= pending_nxt;
        end
    end

    always_comb begin
        rs1_val = (bus.rs1 == '0) ? '0 : rf[bus.rs1];
        rs2_val = (bus.rs2 == '0) ? '0 : rf[bus.rs2];
`ifdef RF_BYPASS_EN
        if (wb_hit1) rs1_val = bus.rd_din;
        if (wb_hit2) rs2_val = bus.rd_din;
`else
`endif
    end

    assign bus.rs1_dout = rs1_val;
    assign bus.rs2_dout = rs2_val;
    assign bus.rs1_busy = pending[bus.rs1] && !wb_hit1;
    assign bus.rs2_busy = pending[bus.rs2] && !wb_hit2;
    assign bus.ecall    = rf[ADDR_W'(ECALL_IDX)];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed test for regfile_sb: expectations are queued per cycle and checked by a separate monitor.
module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct {
        int          cyc;
        int          kind;   // 0 rs1_dout, 1 rs2_dout, 2 rs1_busy, 3 rs2_busy, 4 ecall
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_sb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            0: return "rs1_dout";
            1: return "rs2_dout";
            2: return "rs1_busy";
            3: return "rs2_busy";
            default: return "ecall";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            0: return bus.rs1_dout;
            1: return bus.rs2_dout;
            2: return {31'd0, bus.rs1_busy};
            3: return {31'd0, bus.rs2_busy};
            default: return bus.ecall;
        endcase
    endfunction

    // Monitor: outputs are settled mid-cycle, compare every expectation queued for this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            exp_t e;
            logic [31:0] a;
            e = sb_q.pop_front();
            a = actual(e.kind);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d actual=%h required=%h", kind_name(e.kind), cyc, a, e.val);
            end
        end
    end

    task automatic expect_out(input int kind, input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] rd,
                         input logic [31:0] din, input logic iv, input logic [4:0] ird,
                         input logic [4:0] r1, input logic [4:0] r2);
        reset            = rst;
        bus.write_enable = we;
        bus.rd           = rd;
        bus.rd_din       = din;
        bus.iss_valid    = iv;
        bus.iss_rd       = ird;
        bus.rs1          = r1;
        bus.rs2          = r2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        // Reset clears a written register; write on a reset edge is ignored
        drive(1, 1, 5, 32'h1234, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 1, 5, 32'h99, 1, 5, 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 5, 2);
        expect_out(0, 32'h0);
        expect_out(1, 32'h2ffc);
        expect_out(2, 32'h0);
        expect_out(3, 32'h0);
        expect_out(4, 32'h0);

        // Write/read and register 0
        next_cycle();
        drive(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
        next_cycle();
        drive(1, 1, 0, 32'hFFFFFFFF, 0, 0, 3, 0);
        expect_out(0, 32'hDEADBEEF);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 3, 0);
        expect_out(0, 32'hDEADBEEF);
        expect_out(1, 32'h0);
        expect_out(3, 32'h0);

        // ecall register, never bypassed
        next_cycle();
        drive(1, 1, 17, 32'hA, 0, 0, 17, 0);
        expect_out(4, 32'h0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        expect_out(4, 32'hA);

        // Write/read on the same cycle
        next_cycle();
        drive(1, 1, 7, 32'h55, 0, 0, 7, 3);
`ifdef RF_BYPASS_EN
        expect_out(0, 32'h55);
`else
        expect_out(0, 32'h0);
`endif
        expect_out(1, 32'hDEADBEEF);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 7, 0);
        expect_out(0, 32'h55);

        // Scoreboard set then cleared by writeback
        next_cycle();
        drive(1, 0, 0, 0, 1, 9, 9, 9);
        expect_out(2, 32'h0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 9, 9);
        expect_out(2, 32'h1);
        expect_out(3, 32'h1);
        next_cycle();
        drive(1, 1, 9, 32'h1, 0, 0, 9, 9);
        expect_out(2, 32'h0);
        expect_out(3, 32'h0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 9, 9);
        expect_out(2, 32'h0);
        expect_out(3, 32'h0);
        expect_out(0, 32'h1);

        // Issue and writeback to the same pending register on one edge
        next_cycle();
        drive(1, 0, 0, 0, 1, 4, 0, 0);
        next_cycle();
        drive(1, 1, 4, 32'h44, 1, 4, 4, 0);
        expect_out(2, 32'h0);
        next_cycle();
        drive(1, 0, 0, 0, 1, 0, 4, 0);
        expect_out(2, 32'h1);
        expect_out(0, 32'h44);
        expect_out(3, 32'h0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 4);
        expect_out(2, 32'h0);
        expect_out(3, 32'h1);

        // Reset in the middle of outstanding work
        next_cycle();
        drive(1, 0, 0, 0, 1, 6, 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 6, 0);
        expect_out(2, 32'h1);
        next_cycle();
        drive(0, 1, 6, 32'h66, 0, 0, 6, 4);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 6, 4);
        expect_out(0, 32'h0);
        expect_out(2, 32'h0);
        expect_out(1, 32'h0);
        expect_out(3, 32'h0);
        expect_out(4, 32'h0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 2, 17);
        expect_out(0, 32'h2ffc);
        expect_out(1, 32'h0);

        next_cycle();
        next_cycle();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d pending required=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle CPU register file, intended for the pipelined core.
- Provides two asynchronous read ports, one synchronous write port, an optional write-to-read bypass, and a per-register pending scoreboard.
- The decode stage uses the scoreboard to detect RAW hazards against in-flight producers.
- Also exposes a fixed syscall-argument register (`ecall` output) for halt detection.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- SP_IDX, 2, index of the stack pointer register
- SP_INIT, 32'h2ffc, reset value of register SP_IDX
- ECALL_IDX, 17, index driven onto the `ecall` output

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset asserted)
- rs1  in  ADDR_W  read port 1 index
- rs2  in  ADDR_W  read port 2 index
- rd  in  ADDR_W  writeback index
- rd_din  in  DATA_W  writeback data
- write_enable  in  1  writeback strobe; also clears pending[rd]
- iss_valid  in  1  instruction with destination issued this cycle
- iss_rd  in  ADDR_W  destination of the issued instruction; sets pending[iss_rd]
- rs1_dout  out  DATA_W  read data, port 1
- rs2_dout  out  DATA_W  read data, port 2
- rs1_busy  out  1  pending[rs1], after same-cycle writeback resolution
- rs2_busy  out  1  pending[rs2], after same-cycle writeback resolution
- ecall  out  DATA_W  contents of register ECALL_IDX

Behaviour:
- Single clock domain. The reset is synchronous and active-low; the clock port is named `clk` and the reset port `reset`.
- Reset (reset==0 at a rising edge):
  - every register is cleared to 0, except register SP_IDX, which loads SP_INIT;
  - all pending bits are cleared;
  - write_enable and iss_valid are ignored on that edge.
- Reset values of the outputs after the reset edge:
  - rs*_dout = 0, or SP_INIT when the index equals SP_IDX;
  - rs*_busy = 0;
  - ecall = 0.
- Reset can occur mid-operation: any in-flight pending state is discarded. No recovery cycle is needed; normal operation resumes on the first edge with reset==1.
- Reads are combinational from rf[]. The `ecall` output is always raw rf[ECALL_IDX] and is never bypassed.
- Write: on a rising edge with reset==1, write_enable==1 and rd!=0, rf[rd] <= rd_din. Latency is 1 cycle.
- Register 0:
  - writes are discarded;
  - it always reads 0;
  - pending[0] is never set, so an issue with iss_rd==0 has no effect.
- Scoreboard, per register r != 0 (next-state priority in this order):
  - iss_valid && iss_rd==r: pending[r] <= 1. Issue wins over a same-cycle writeback to the same register, because the new producer is still outstanding.
  - else write_enable && rd==r: pending[r] <= 0.
  - else: hold.
- Issuing to an already-pending register leaves the bit at 1. The single bit tracks only the youngest producer; the pipeline guarantees in-order writeback.
- A writeback to a register that is not pending just writes data; the pending bit stays 0.
- Busy outputs:
  - rsN_busy = pending[rsN] && !(write_enable && rd==rsN && rd!=0).
  - A same-cycle writeback therefore releases the hazard combinationally.
  - The current cycle's iss_valid does not affect busy.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: when write_enable==1, rd!=0 and rd==rsN, rsN_dout = rd_din in the same cycle (write-first forwarding). Otherwise rsN_dout = rf[rsN].
- Undefined: rsN_dout = rf[rsN] always, so new data becomes visible one cycle after the write edge. In this build, rsN_busy still drops in the writeback cycle; the integrating pipeline must add one stall cycle itself.

Test Plan:
- Reset: hold reset=0 for 2 edges after writing x5=0x1234 -> rs1=5 reads 0; rs2=2 reads 0x2ffc; all busy=0; ecall=0.
- Write/read and x0: write x3=0xDEADBEEF, then x0=0xFFFFFFFF -> next cycle rs1=3 reads 0xDEADBEEF and rs2=0 reads 0. Write x17=0xA -> ecall=0xA one cycle later.
- Bypass: write_enable=1, rd=7, rd_din=0x55, rs1=7 in the same cycle:
  - RF_BYPASS_EN defined -> rs1_dout=0x55 that cycle;
  - undefined -> old value that cycle, 0x55 the next cycle.
- Scoreboard basic: iss_valid, iss_rd=9 -> next cycle rs1=9 busy=1. In a later cycle, write_enable with rd=9 -> busy=0 in that same cycle and in all following cycles.
- Simultaneous events: iss_rd=4 and write rd=4 on the same edge, with pending[4]=1 -> pending[4] stays 1 and rf[4] is updated. iss_rd=0 -> rs1=0 busy never asserts.
- Reset mid-operation: pending[6]=1, then reset=0 for 1 edge -> busy for index 6 =0 and rf[6]=0. A write with write_enable=1 on the reset edge is not applied.
